// File: rtl/riscv_rvfimon_checker.sv
// Multi-channel RVFI monitor error collector: grace period after reset, then
// captures the first failing channel/code/cycle and counts error cycles up to a fatal threshold.
module riscv_rvfimon_checker #(
  parameter int unsigned NCHAN        = 2,
  parameter int unsigned ERRW         = 16,
  parameter int unsigned GRACE        = 4,
  parameter int unsigned FATAL_THRESH = 1,
  parameter int unsigned CNTW         = 16,
  localparam int unsigned CHW         = (NCHAN > 1) ? $clog2(NCHAN) : 1
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [NCHAN*ERRW-1:0] errcode,
  input  logic [NCHAN-1:0]      chan_enable,
  input  logic                  clear,
  output logic                  armed,
  output logic                  error_any,
  output logic [NCHAN-1:0]      error_sticky,
  output logic [CHW-1:0]        first_chan,
  output logic [ERRW-1:0]       first_code,
  output logic [CNTW-1:0]       first_cycle,
  output logic [CNTW-1:0]       err_count,
  output logic                  fatal
);

  localparam int unsigned GW  = (GRACE > 1) ? $clog2(GRACE) : 1;
  localparam logic [63:0] THR = 64'(FATAL_THRESH);

  typedef enum logic [1:0] {S_GRACE, S_ARMED, S_TRIPPED, S_FATAL} state_t;

  state_t           r_state;
  logic [GW-1:0]    r_grace_cnt;
  logic [CNTW-1:0]  r_cycle;
  logic             r_armed;
  logic             r_error_any;
  logic [NCHAN-1:0] r_sticky;
  logic [CHW-1:0]   r_first_chan;
  logic [ERRW-1:0]  r_first_code;
  logic [CNTW-1:0]  r_first_cycle;
  logic [CNTW-1:0]  r_err_count;
  logic             r_fatal;

  logic [NCHAN-1:0] w_hit;
  logic             w_any;
  logic [CHW-1:0]   w_first_chan;
  logic [ERRW-1:0]  w_first_code;
  logic [CNTW-1:0]  w_cnt_inc;
  logic             w_reach;

  always_comb begin
    logic found;
    found        = 1'b0;
    w_hit        = '0;
    w_first_chan = '0;
    w_first_code = '0;
    for (int unsigned i = 0; i < NCHAN; i++) begin
      w_hit[i] = chan_enable[i] && (errcode[i*ERRW +: ERRW] != '0);
    end
    // Upward scan with a found flag picks the lowest-index hit.
    for (int unsigned i = 0; i < NCHAN; i++) begin
      if (w_hit[i] && !found) begin
        found        = 1'b1;
        w_first_chan = CHW'(i);
        w_first_code = errcode[i*ERRW +: ERRW];
      end
    end
    w_any     = |w_hit;
    w_cnt_inc = (r_err_count == '1) ? r_err_count : r_err_count + CNTW'(1);
    w_reach   = (64'(w_cnt_inc) >= THR);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state       <= S_GRACE;
      r_grace_cnt   <= '0;
      r_cycle       <= '0;
      r_armed       <= 1'b0;
      r_error_any   <= 1'b0;
      r_sticky      <= '0;
      r_first_chan  <= '0;
      r_first_code  <= '0;
      r_first_cycle <= '0;
      r_err_count   <= '0;
      r_fatal       <= 1'b0;
    end else begin
      case (r_state)
        S_GRACE: begin
          if (r_grace_cnt == GW'(GRACE - 1)) begin
            r_state <= S_ARMED;
            r_armed <= 1'b1;
          end else begin
            r_grace_cnt <= r_grace_cnt + GW'(1);
          end
        end
        default: begin
          if (r_cycle != '1) r_cycle <= r_cycle + CNTW'(1);
          if (clear) begin
            r_state       <= S_ARMED;
            r_error_any   <= 1'b0;
            r_sticky      <= '0;
            r_first_chan  <= '0;
            r_first_code  <= '0;
            r_first_cycle <= '0;
            r_err_count   <= '0;
            r_fatal       <= 1'b0;
          end else begin
            r_error_any <= w_any;
            if (w_any) begin
              r_sticky    <= r_sticky | w_hit;
              r_err_count <= w_cnt_inc;
              if (r_state == S_ARMED) begin
                r_first_chan  <= w_first_chan;
                r_first_code  <= w_first_code;
                r_first_cycle <= r_cycle;
              end
              if (w_reach) begin
                r_state <= S_FATAL;
                r_fatal <= 1'b1;
              end else if (r_state == S_ARMED) begin
                r_state <= S_TRIPPED;
              end
            end
          end
        end
      endcase
    end
  end

  assign armed        = r_armed;
  assign error_any    = r_error_any;
  assign error_sticky = r_sticky;
  assign first_chan   = r_first_chan;
  assign first_code   = r_first_code;
  assign first_cycle  = r_first_cycle;
  assign err_count    = r_err_count;
  assign fatal        = r_fatal;

endmodule

// File: tb/tb_riscv_rvfimon_checker.sv
// Scoreboard bench for riscv_rvfimon_checker: two parameterisations share stimulus,
// a behavioural model predicts outputs per edge and a monitor compares them.
module tb_riscv_rvfimon_checker;

  localparam int GRA = 4, THA = 1, CMA = 65535;
  localparam int GRB = 2, THB = 3, CMB = 15;

  logic        clock;
  logic        reset;
  logic [31:0] errcode;
  logic [1:0]  chan_enable;
  logic        clear;

  logic        a_armed, a_any, a_fatal, a_fchan;
  logic [1:0]  a_sticky;
  logic [15:0] a_fcode, a_fcycle, a_count;
  logic        b_armed, b_any, b_fatal, b_fchan;
  logic [1:0]  b_sticky;
  logic [15:0] b_fcode;
  logic [3:0]  b_fcycle, b_count;

  riscv_rvfimon_checker #(.NCHAN(2), .ERRW(16), .GRACE(GRA), .FATAL_THRESH(THA), .CNTW(16)) dut_a (
    .clock(clock), .reset(reset), .errcode(errcode), .chan_enable(chan_enable), .clear(clear),
    .armed(a_armed), .error_any(a_any), .error_sticky(a_sticky), .first_chan(a_fchan),
    .first_code(a_fcode), .first_cycle(a_fcycle), .err_count(a_count), .fatal(a_fatal));

  riscv_rvfimon_checker #(.NCHAN(2), .ERRW(16), .GRACE(GRB), .FATAL_THRESH(THB), .CNTW(4)) dut_b (
    .clock(clock), .reset(reset), .errcode(errcode), .chan_enable(chan_enable), .clear(clear),
    .armed(b_armed), .error_any(b_any), .error_sticky(b_sticky), .first_chan(b_fchan),
    .first_code(b_fcode), .first_cycle(b_fcycle), .err_count(b_count), .fatal(b_fatal));

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  typedef struct {
    int edges; int cycle; bit captured; int fchan; int fcode; int fcycle;
    int count; bit [1:0] sticky; bit any;
  } mdl_t;

  typedef struct {
    bit armed; bit any; bit [1:0] sticky; int fchan; int fcode; int fcycle; int count; bit fatal;
  } exp_t;

  typedef struct { exp_t a; exp_t b; } pair_t;

  pair_t q[$];
  mdl_t  ma, mb;
  int    n_checks = 0;
  int    n_errors = 0;
  bit    run = 1'b0;

  function automatic mdl_t step(mdl_t s, int grace, int cmax, logic [31:0] ec, logic [1:0] en, bit clr);
    bit [1:0] hit;
    if (s.edges < grace) begin
      s.edges++;
      return s;
    end
    hit[0] = en[0] && (ec[15:0] != 16'h0);
    hit[1] = en[1] && (ec[31:16] != 16'h0);
    if (clr) begin
      s.captured = 0; s.fchan = 0; s.fcode = 0; s.fcycle = 0;
      s.count = 0; s.sticky = 0; s.any = 0;
    end else begin
      s.any = (hit != 2'b00);
      if (s.any) begin
        s.sticky |= hit;
        if (s.count < cmax) s.count++;
        if (!s.captured) begin
          s.captured = 1;
          s.fchan  = hit[0] ? 0 : 1;
          s.fcode  = hit[0] ? int'(ec[15:0]) : int'(ec[31:16]);
          s.fcycle = s.cycle;
        end
      end
    end
    if (s.cycle < cmax) s.cycle++;
    return s;
  endfunction

  function automatic exp_t to_exp(mdl_t s, int grace, int thresh);
    exp_t e;
    e.armed  = (s.edges >= grace);
    e.any    = s.any;
    e.sticky = s.sticky;
    e.fchan  = s.fchan;
    e.fcode  = s.fcode;
    e.fcycle = s.fcycle;
    e.count  = s.count;
    e.fatal  = (s.count >= thresh);
    return e;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic cmp(input string tag, input exp_t e, input logic armed, input logic any,
                     input logic [1:0] sticky, input logic fchan, input logic [15:0] fcode,
                     input logic [15:0] fcycle, input logic [15:0] cnt, input logic fatal);
    chk({tag, ".armed"},        64'(armed),  64'(e.armed));
    chk({tag, ".error_any"},    64'(any),    64'(e.any));
    chk({tag, ".error_sticky"}, 64'(sticky), 64'(e.sticky));
    chk({tag, ".first_chan"},   64'(fchan),  64'(e.fchan));
    chk({tag, ".first_code"},   64'(fcode),  64'(e.fcode));
    chk({tag, ".first_cycle"},  64'(fcycle), 64'(e.fcycle));
    chk({tag, ".err_count"},    64'(cnt),    64'(e.count));
    chk({tag, ".fatal"},        64'(fatal),  64'(e.fatal));
  endtask

  // Monitor: one expected pair per rising edge while stimulus is running.
  initial begin
    pair_t p;
    forever begin
      @(posedge clock);
      #1;
      if (run) begin
        if (q.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL scoreboard: got empty queue expected entry at %0t", $time);
        end else begin
          p = q.pop_front();
          cmp("a", p.a, a_armed, a_any, a_sticky, a_fchan, a_fcode, a_fcycle, a_count, a_fatal);
          cmp("b", p.b, b_armed, b_any, b_sticky, b_fchan, b_fcode, 16'(b_fcycle), 16'(b_count), b_fatal);
        end
      end
    end
  end

  // Called at a falling edge: apply inputs, predict the next rising edge, return at the next falling edge.
  task automatic cyc(input logic [31:0] ec, input logic [1:0] en, input bit clr);
    pair_t p;
    errcode     = ec;
    chan_enable = en;
    clear       = clr;
    run         = 1'b1;
    @(posedge clock);
    if (!reset) begin
      ma = '{default: 0};
      mb = '{default: 0};
    end else begin
      ma = step(ma, GRA, CMA, ec, en, clr);
      mb = step(mb, GRB, CMB, ec, en, clr);
    end
    p.a = to_exp(ma, GRA, THA);
    p.b = to_exp(mb, GRB, THB);
    q.push_back(p);
    @(negedge clock);
  endtask

  task automatic rnd_cyc(input int clr_odds);
    logic [31:0] ec;
    ec[15:0]  = ($urandom_range(0, 2) == 0) ? 16'($urandom) : 16'h0;
    ec[31:16] = ($urandom_range(0, 2) == 0) ? 16'($urandom) : 16'h0;
    cyc(ec, 2'($urandom), ($urandom_range(0, clr_odds) == 0));
  endtask

  task automatic async_reset_check();
    exp_t z;
    z = '{default: 0};
    #2 reset = 1'b0;
    #1;
    cmp("a_async", z, a_armed, a_any, a_sticky, a_fchan, a_fcode, a_fcycle, a_count, a_fatal);
    cmp("b_async", z, b_armed, b_any, b_sticky, b_fchan, b_fcode, 16'(b_fcycle), 16'(b_count), b_fatal);
    ma = '{default: 0};
    mb = '{default: 0};
  endtask

  initial begin
    reset       = 1'b0;
    errcode     = '0;
    chan_enable = '0;
    clear       = 1'b0;
    ma          = '{default: 0};
    mb          = '{default: 0};
    @(negedge clock);
    repeat (2) cyc(32'h0, 2'b11, 1'b0);
    reset = 1'b1;

    // Error held from reset release; grace hides it until armed.
    repeat (8) cyc(32'h0000_0001, 2'b11, 1'b0);

    // Simultaneous two-channel error picks channel 0; threshold reached on third cycle.
    cyc(32'h0, 2'b11, 1'b1);
    cyc(32'h0002_0005, 2'b11, 1'b0);
    repeat (2) cyc(32'h0000_0001, 2'b11, 1'b0);

    // Disabled channel is ignored, then channel 1 trips.
    cyc(32'h0, 2'b11, 1'b1);
    repeat (10) cyc(32'h0000_FFFF, 2'b10, 1'b0);
    cyc(32'h0010_0000, 2'b10, 1'b0);

    // Clear wins over a same-cycle error; the next error is a new first capture.
    cyc(32'h0010_0000, 2'b11, 1'b1);
    cyc(32'h0010_0000, 2'b11, 1'b0);

    // Long error run saturates the narrow counters.
    repeat (20) cyc(32'h0003_0007, 2'b11, 1'b0);

    repeat (300) rnd_cyc(15);

    // Async reset while fatal, held across edges, then normal operation again.
    cyc(32'h0, 2'b11, 1'b1);
    repeat (3) cyc(32'h0001_0001, 2'b11, 1'b0);
    async_reset_check();
    repeat (3) cyc(32'h0001_0001, 2'b11, 1'b0);
    reset = 1'b1;
    repeat (8) cyc(32'h0001_0000, 2'b11, 1'b0);
    repeat (60) rnd_cyc(20);

    run = 1'b0;
    n_checks++;
    if (q.size() != 0) begin
      n_errors++;
      $display("FAIL scoreboard_drain: got %0d entries expected 0", q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
